pixel_stacker: RTL and testbench

- Packs a 16-bit pixel AXI-Stream into 128-bit phrase AXI-Stream, 8 pixels per phrase.
- Sits on the write path toward the DRAM/MIG FIFO; inverse of the phrase-to-pixel unstacker on the read path.
- Lane order: first accepted pixel in bits [15:0], eighth pixel in bits [127:112].
- pixel_tlast closes a phrase early; unused upper lanes are padded.

---
 rtl/pixel_stacker_if.sv | 33 +++
 rtl/pixel_stacker.sv | 113 +++++++++++
 tb/tb_pixel_stacker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stacker_if.sv
// Handshake bundle for pixel_stacker: 16-bit pixel AXI-Stream in, 128-bit phrase AXI-Stream out.
// PIXEL_STACKER_TKEEP_EN adds the chunk_tkeep lane-valid mask.
interface pixel_stacker_if;
   logic         pixel_tvalid;
   logic         pixel_tready;
   logic [15:0]  pixel_tdata;
   logic         pixel_tlast;
   logic         chunk_tvalid;
   logic         chunk_tready;
   logic [127:0] chunk_tdata;
   logic         chunk_tlast;
`ifdef PIXEL_STACKER_TKEEP_EN
   logic [15:0]  chunk_tkeep;

   modport master (
      output pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
      input  pixel_tready, chunk_tvalid, chunk_tdata, chunk_tlast, chunk_tkeep
   );
   modport slave (
      input  pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
      output pixel_tready, chunk_tvalid, chunk_tdata, chunk_tlast, chunk_tkeep
   );
`else
   modport master (
      output pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
      input  pixel_tready, chunk_tvalid, chunk_tdata, chunk_tlast
   );
   modport slave (
      input  pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
      output pixel_tready, chunk_tvalid, chunk_tdata, chunk_tlast
   );
`endif
endinterface

// File: rtl/pixel_stacker.sv
// Packs eight 16-bit pixels per 128-bit phrase (first pixel in the low lane); tlast closes a phrase early.
// Optional macro PIXEL_STACKER_TKEEP_EN adds a registered chunk_tkeep marking real-pixel lanes.
module pixel_stacker #(
   parameter logic [15:0] PAD_WORD = 16'h0000
) (
   input  logic           clk_in,
   input  logic           rst_in,
   pixel_stacker_if.slave bus
);
   localparam int DATA_W   = 16;
   localparam int LANES    = 8;
   localparam int PHRASE_W = DATA_W * LANES;
   localparam int KEEP_W   = PHRASE_W / 8;

   logic [2:0]          count_q, count_d;
   logic [PHRASE_W-1:0] acc_q, acc_d;
   logic [PHRASE_W-1:0] data_q, data_d;
   logic                last_q, last_d;
   logic                vld_q, vld_d;
   logic                ready;
   logic                accept_in;
   logic                accept_out;
   logic                complete;

   // Lanes below cnt come from the accumulator, lane cnt takes the new word, the rest are padding.
   function automatic logic [PHRASE_W-1:0] build_phrase(input logic [PHRASE_W-1:0] acc,
                                                        input logic [2:0]          cnt,
                                                        input logic [DATA_W-1:0]   word);
      logic [PHRASE_W-1:0] phrase;
      phrase = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(cnt))       phrase[i*DATA_W +: DATA_W] = acc[i*DATA_W +: DATA_W];
         else if (i == int'(cnt)) phrase[i*DATA_W +: DATA_W] = word;
         else                     phrase[i*DATA_W +: DATA_W] = PAD_WORD;
      end
      return phrase;
   endfunction

`ifdef PIXEL_STACKER_TKEEP_EN
   logic [KEEP_W-1:0] keep_q, keep_d;

   function automatic logic [KEEP_W-1:0] build_keep(input logic [2:0] cnt);
      logic [KEEP_W-1:0] keep;
      keep = '0;
      for (int i = 0; i < LANES; i++) begin
         keep[2*i +: 2] = (i <= int'(cnt)) ? 2'b11 : 2'b00;
      end
      return keep;
   endfunction

   assign bus.chunk_tkeep = keep_q;
`endif

   // Stall only when the incoming word would complete a phrase while the output is still held.
   assign ready      = !vld_q || bus.chunk_tready || (count_q != 3'd7 && !bus.pixel_tlast);
   assign accept_in  = bus.pixel_tvalid && ready;
   assign accept_out = vld_q && bus.chunk_tready;
   assign complete   = accept_in && (count_q == 3'd7 || bus.pixel_tlast);

   assign bus.pixel_tready = ready;
   assign bus.chunk_tvalid = vld_q;
   assign bus.chunk_tdata  = data_q;
   assign bus.chunk_tlast  = last_q;

   always_comb begin
      count_d = count_q;
      acc_d   = acc_q;
      data_d  = data_q;
      last_d  = last_q;
      vld_d   = vld_q;
`ifdef PIXEL_STACKER_TKEEP_EN
      keep_d  = keep_q;
`endif
      if (complete) begin
         data_d  = build_phrase(acc_q, count_q, bus.pixel_tdata);
         last_d  = bus.pixel_tlast;
         vld_d   = 1'b1;
         count_d = 3'd0;
         acc_d   = {LANES{PAD_WORD}};
`ifdef PIXEL_STACKER_TKEEP_EN
         keep_d  = build_keep(count_q);
`endif
      end else begin
         if (accept_in) begin
            acc_d[{count_q, 4'b0000} +: DATA_W] = bus.pixel_tdata;
            count_d = count_q + 3'd1;
         end
         if (accept_out) vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         count_q <= 3'd0;
         acc_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         vld_q   <= 1'b0;
`ifdef PIXEL_STACKER_TKEEP_EN
         keep_q  <= '0;
`endif
      end else begin
         count_q <= count_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
`ifdef PIXEL_STACKER_TKEEP_EN
         keep_q  <= keep_d;
`endif
      end
   end
endmodule

// File: tb/tb_pixel_stacker.sv
// Scoreboard bench for pixel_stacker: tests queue hand-computed phrases, a negedge monitor pops and compares.
module tb_pixel_stacker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pixel_stacker_if bus();
   pixel_stacker #(.PAD_WORD(16'hDEAD)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

   typedef struct packed {
      logic [127:0] data;
      logic         last;
      logic [15:0]  keep;
   } exp_t;

   exp_t q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   cyc      = 0;
   int   last_pop = -1;
   bit   spacing_en = 1'b0;
   int   cnt = 0;
   bit   out_full = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h want %h", name, act, req);
   endtask

   task automatic fail(input string name);
      chk_cnt++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [127:0] seq(input logic [15:0] b);
      logic [127:0] r;
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = b + 16'(i);
      return r;
   endfunction

   task automatic expect_phrase(input logic [127:0] d, input logic l, input logic [15:0] k);
      exp_t e;
      e.data = d; e.last = l; e.keep = k;
      q.push_back(e);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare the presented phrase against the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (!rst && bus.chunk_tvalid) begin
         if (q.size() == 0) begin
            fail("unexpected_phrase");
         end else begin
            exp_t e;
            e = q[0];
            check(bus.chunk_tready ? "phrase_data" : "hold_data", bus.chunk_tdata, e.data);
            check("phrase_last", {127'b0, bus.chunk_tlast}, {127'b0, e.last});
`ifdef PIXEL_STACKER_TKEEP_EN
            check("phrase_keep", {112'b0, bus.chunk_tkeep}, {112'b0, e.keep});
`endif
            if (bus.chunk_tready) begin
               void'(q.pop_front());
               out_full = 1'b0;
               if (spacing_en && last_pop >= 0) check("phrase_spacing", 128'(cyc - last_pop), 128'd8);
               last_pop = cyc;
            end
         end
      end
   end

   // Drive one pixel, holding it until accepted; checks pixel_tready against the bench's own state.
   task automatic send(input logic [15:0] d, input bit l);
      int waits;
      bit acc;
      bit exp_rdy;
      waits = 0;
      acc = 1'b0;
      bus.pixel_tvalid = 1'b1;
      bus.pixel_tdata  = d;
      bus.pixel_tlast  = l;
      while (!acc && waits <= 200) begin
         @(negedge clk);
         exp_rdy = !out_full || bus.chunk_tready || (cnt != 7 && !l);
         check("pixel_tready", {127'b0, bus.pixel_tready}, {127'b0, exp_rdy});
         acc = bus.pixel_tready;
         @(posedge clk);
         #1;
         if (!acc) waits++;
      end
      if (!acc) fail("send_timeout");
      else if (l || cnt == 7) begin
         cnt = 0;
         out_full = 1'b1;
      end else cnt++;
   endtask

   task automatic idle();
      bus.pixel_tvalid = 1'b0;
      bus.pixel_tlast  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", 128'(q.size()), 128'd0);
   endtask

   initial begin
      bus.pixel_tvalid = 1'b0;
      bus.pixel_tdata  = 16'h0;
      bus.pixel_tlast  = 1'b0;
      bus.chunk_tready = 1'b1;

      // Reset state
      #3;
      check("reset_tvalid", {127'b0, bus.chunk_tvalid}, 128'd0);
      check("reset_tdata", bus.chunk_tdata, 128'd0);
      check("reset_tlast", {127'b0, bus.chunk_tlast}, 128'd0);
      check("reset_pixel_tready", {127'b0, bus.pixel_tready}, 128'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Full phrase
      expect_phrase(128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0, 16'hFFFF);
      for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
      idle();
      drain();

      // Partial phrase closed by tlast, then a fresh phrase must start at lane 0
      expect_phrase(128'hDEAD_DEAD_DEAD_DEAD_DEAD_000C_000B_000A, 1'b1, 16'h003F);
      send(16'h000A, 1'b0);
      send(16'h000B, 1'b0);
      send(16'h000C, 1'b1);
      expect_phrase(seq(16'h0010), 1'b0, 16'hFFFF);
      for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), 1'b0);
      idle();
      drain();

      // Backpressure: 16 pixels with chunk_tready low, released later
      bus.chunk_tready = 1'b0;
      expect_phrase(seq(16'h0100), 1'b0, 16'hFFFF);
      expect_phrase(seq(16'h0108), 1'b0, 16'hFFFF);
      fork
         begin
            for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 1'b0);
            idle();
         end
         begin
            repeat (22) @(posedge clk);
            #1;
            bus.chunk_tready = 1'b1;
         end
      join
      drain();

      // Full rate: 64 pixels, a phrase every 8 cycles
      spacing_en = 1'b1;
      last_pop = -1;
      for (int p = 0; p < 8; p++) expect_phrase(seq(16'h0200 + 16'(8 * p)), 1'b0, 16'hFFFF);
      for (int i = 0; i < 64; i++) send(16'h0200 + 16'(i), 1'b0);
      idle();
      drain();
      spacing_en = 1'b0;

      // tlast at lane 0 and at lane 7
      expect_phrase(128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_0300, 1'b1, 16'h0003);
      send(16'h0300, 1'b1);
      expect_phrase(seq(16'h0310), 1'b1, 16'hFFFF);
      for (int i = 0; i < 8; i++) send(16'h0310 + 16'(i), i == 7);
      idle();
      drain();

      // Async reset with a held phrase and a partial accumulator
      bus.chunk_tready = 1'b0;
      expect_phrase(seq(16'h0400), 1'b0, 16'hFFFF);
      for (int i = 0; i < 8; i++) send(16'h0400 + 16'(i), 1'b0);
      for (int i = 0; i < 5; i++) send(16'h0500 + 16'(i), 1'b0);
      idle();
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_tvalid", {127'b0, bus.chunk_tvalid}, 128'd0);
      check("async_reset_tdata", bus.chunk_tdata, 128'd0);
      check("async_reset_tlast", {127'b0, bus.chunk_tlast}, 128'd0);
      q.delete();
      cnt = 0;
      out_full = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.chunk_tready = 1'b1;
      @(posedge clk); #1;
      expect_phrase(seq(16'h0600), 1'b0, 16'hFFFF);
      for (int i = 0; i < 8; i++) send(16'h0600 + 16'(i), 1'b0);
      idle();
      drain();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
